led_pattern_gen: RTL and testbench

Parametrised LED pattern generator that replaces the fixed 8-bit free-running blinky counter in board top levels. It divides the system clock into a step rate and produces one of four selectable patterns on `NUM_LEDS` outputs: binary count, bouncing scanner, PWM breathing, or off. It sits directly under `top`, driven by the power-on reset shifter, and its outputs go straight to the `out_leds` pins.

---
 rtl/led_pattern_gen.sv | 132 +++++++++++++
 tb/tb_led_pattern_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: divides the clock into pattern steps and drives one of
// four patterns (binary count, bouncing scanner, PWM breathing, off) onto NUM_LEDS pins.
module led_pattern_gen #(
    parameter int NUM_LEDS = 8,
    parameter int STEP_DIV = 1000000,
    parameter int PWM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_run,
    input  logic [1:0]          in_mode,
    output logic [NUM_LEDS-1:0] out_leds,
    output logic                out_step,
    output logic [1:0]          out_mode
);

    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int POS_W = $clog2(NUM_LEDS);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0]    POS_PEN  = POS_W'(NUM_LEDS - 2);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [PWM_BITS-1:0] LVL_PEN  = LVL_MAX - PWM_BITS'(1);

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_e;

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    mode_e               mode_q, mode_d;
    logic [NUM_LEDS-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                scan_dn_q, scan_dn_d;
    logic [PWM_BITS-1:0] lvl_q, lvl_d;
    logic                lvl_dn_q, lvl_dn_d;
    logic                step_q, step_d;

    always_comb begin
        presc_d   = presc_q;
        pwm_d     = pwm_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        scan_dn_d = scan_dn_q;
        lvl_d     = lvl_q;
        lvl_dn_d  = lvl_dn_q;
        step_d    = 1'b0;
        if (in_run) begin
            pwm_d = pwm_q + PWM_BITS'(1);
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                step_d  = 1'b1;
                // A mode switch restarts the pattern from its initial state
                // instead of advancing it on this step.
                if (mode_e'(in_mode) != mode_q) begin
                    mode_d    = mode_e'(in_mode);
                    cnt_d     = '0;
                    pos_d     = '0;
                    scan_dn_d = 1'b0;
                    lvl_d     = '0;
                    lvl_dn_d  = 1'b0;
                end else begin
                    case (mode_q)
                        MODE_COUNT: cnt_d = cnt_q + NUM_LEDS'(1);
                        MODE_SCAN: begin
                            if (!scan_dn_q) begin
                                pos_d = pos_q + POS_W'(1);
                                if (pos_q == POS_PEN) scan_dn_d = 1'b1;
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                                if (pos_q == POS_W'(1)) scan_dn_d = 1'b0;
                            end
                        end
                        MODE_BREATHE: begin
                            if (!lvl_dn_q) begin
                                lvl_d = lvl_q + PWM_BITS'(1);
                                if (lvl_q == LVL_PEN) lvl_dn_d = 1'b1;
                            end else begin
                                lvl_d = lvl_q - PWM_BITS'(1);
                                if (lvl_q == PWM_BITS'(1)) lvl_dn_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q   <= '0;
            pwm_q     <= '0;
            mode_q    <= MODE_COUNT;
            cnt_q     <= '0;
            pos_q     <= '0;
            scan_dn_q <= 1'b0;
            lvl_q     <= '0;
            lvl_dn_q  <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            pwm_q     <= pwm_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            scan_dn_q <= scan_dn_d;
            lvl_q     <= lvl_d;
            lvl_dn_q  <= lvl_dn_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        out_leds = '0;
        case (mode_q)
            MODE_COUNT:   out_leds = cnt_q;
            MODE_SCAN:    out_leds = NUM_LEDS'(1) << pos_q;
            MODE_BREATHE: out_leds = {NUM_LEDS{pwm_q < lvl_q}};
            default:      out_leds = '0;
        endcase
    end

    assign out_step = step_q;
    assign out_mode = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: a cycle scoreboard fed by a behavioural model, plus
// directed step-latency and pattern-sequence checks.
module tb_led_pattern_gen;

    localparam int NUM_LEDS = 4;
    localparam int STEP_DIV = 4;
    localparam int PWM_BITS = 2;
    localparam int LVL_MAX  = (1 << PWM_BITS) - 1;
    localparam int SCAN_PER = 2 * (NUM_LEDS - 1);
    localparam int BRE_PER  = 2 * LVL_MAX;

    logic                clock;
    logic                reset;
    logic                in_run;
    logic [1:0]          in_mode;
    logic [NUM_LEDS-1:0] out_leds;
    logic                out_step;
    logic [1:0]          out_mode;

    led_pattern_gen #(
        .NUM_LEDS(NUM_LEDS),
        .STEP_DIV(STEP_DIV),
        .PWM_BITS(PWM_BITS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .in_run  (in_run),
        .in_mode (in_mode),
        .out_leds(out_leds),
        .out_step(out_step),
        .out_mode(out_mode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: steps taken since the active mode was entered.
    int       m_presc = 0;
    int       m_pwm   = 0;
    int       m_mode  = 0;
    int       m_k     = 0;
    logic     m_step  = 1'b0;
    logic [6:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_LEDS-1:0] model_leds();
        int t;
        int v;
        logic [NUM_LEDS-1:0] r;
        r = '0;
        case (m_mode)
            0: r = NUM_LEDS'(m_k % (1 << NUM_LEDS));
            1: begin
                t = m_k % SCAN_PER;
                v = (t < NUM_LEDS) ? t : SCAN_PER - t;
                r = NUM_LEDS'(1 << v);
            end
            2: begin
                t = m_k % BRE_PER;
                v = (t <= LVL_MAX) ? t : BRE_PER - t;
                r = (m_pwm < v) ? '1 : '0;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic cycle(input logic run, input logic [1:0] mode, input logic rst);
        logic [6:0] got;
        reset   = rst;
        in_run  = run;
        in_mode = mode;
        if (rst) begin
            m_presc = 0; m_pwm = 0; m_mode = 0; m_k = 0; m_step = 1'b0;
        end else if (run) begin
            m_pwm = (m_pwm + 1) % (LVL_MAX + 1);
            if (m_presc == STEP_DIV - 1) begin
                m_presc = 0;
                m_step  = 1'b1;
                if (int'(mode) != m_mode) begin
                    m_mode = int'(mode);
                    m_k    = 0;
                end else begin
                    m_k++;
                end
            end else begin
                m_presc++;
                m_step = 1'b0;
            end
        end else begin
            m_step = 1'b0;
        end
        sb_q.push_back({m_step, 2'(m_mode), model_leds()});
        @(posedge clock);
        #1;
        got = {out_step, out_mode, out_leds};
        check("scoreboard", 32'(got), 32'(sb_q.pop_front()));
    endtask

    // Runs until out_step is seen; n = running edges taken, 0 if the bound expired.
    task automatic step_wait(input logic [1:0] mode, input int max, output int n);
        n = 0;
        for (int i = 1; i <= max; i++) begin
            cycle(1'b1, mode, 1'b0);
            if (out_step === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 2'd0, 1'b1);
        cycle(1'b0, 2'd0, 1'b1);
        check("rst_leds", 32'(out_leds), 32'd0);
        check("rst_step", 32'(out_step), 32'd0);
        check("rst_mode", 32'(out_mode), 32'd0);
    endtask

    logic [3:0] scan_tbl [8];
    int         bre_tbl  [8];

    initial begin
        int n;
        int ones;
        logic [NUM_LEDS-1:0] held;
        logic [1:0] rmode;

        scan_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        bre_tbl  = '{0, 1, 2, 3, 2, 1, 0, 1};
        reset = 1'b1; in_run = 1'b0; in_mode = 2'd0;

        // Count
        do_reset();
        for (int s = 1; s <= 16; s++) begin
            step_wait(2'd0, 8, n);
            check("count_lat", 32'(n), 32'd4);
            check("count_leds", 32'(out_leds), 32'(s % 16));
        end

        // Scanner
        do_reset();
        for (int s = 0; s < 8; s++) begin
            step_wait(2'd1, 8, n);
            check("scan_lat", 32'(n), 32'd4);
            check("scan_mode", 32'(out_mode), 32'd1);
            check("scan_leds", 32'(out_leds), 32'(scan_tbl[s]));
        end

        // Breathe: four consecutive cycles sweep every PWM phase
        do_reset();
        for (int s = 0; s < 8; s++) begin
            step_wait(2'd2, 8, n);
            check("bre_lat", 32'(n), (s == 0) ? 32'd4 : 32'd1);
            ones = int'(out_leds[0]);
            for (int c = 0; c < 3; c++) begin
                cycle(1'b1, 2'd2, 1'b0);
                ones += int'(out_leds[0]);
            end
            check("bre_level", 32'(ones), 32'(bre_tbl[s]));
        end

        // Pause with prescaler at 2
        do_reset();
        step_wait(2'd0, 8, n);
        check("pause_first", 32'(out_leds), 32'd1);
        cycle(1'b1, 2'd0, 1'b0);
        cycle(1'b1, 2'd0, 1'b0);
        held = out_leds;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 2'd0, 1'b0);
            check("pause_leds", 32'(out_leds), 32'(held));
            check("pause_step", 32'(out_step), 32'd0);
        end
        step_wait(2'd0, 8, n);
        check("resume_lat", 32'(n), 32'd2);
        check("resume_leds", 32'(out_leds), 32'd2);

        // Mode glitch between steps, then held mode 3
        cycle(1'b1, 2'd1, 1'b0);
        cycle(1'b1, 2'd1, 1'b0);
        step_wait(2'd0, 8, n);
        check("glitch_lat", 32'(n), 32'd2);
        check("glitch_mode", 32'(out_mode), 32'd0);
        check("glitch_leds", 32'(out_leds), 32'd3);
        step_wait(2'd3, 8, n);
        check("off_lat", 32'(n), 32'd4);
        check("off_mode", 32'(out_mode), 32'd3);
        check("off_leds", 32'(out_leds), 32'd0);

        // Reset coinciding with a step edge while scanning at pos 2
        do_reset();
        for (int s = 0; s < 3; s++) step_wait(2'd1, 8, n);
        check("mid_pos2", 32'(out_leds), 32'b0100);
        for (int c = 0; c < 3; c++) cycle(1'b1, 2'd1, 1'b0);
        cycle(1'b1, 2'd1, 1'b1);
        check("mid_rst_leds", 32'(out_leds), 32'd0);
        check("mid_rst_mode", 32'(out_mode), 32'd0);
        check("mid_rst_step", 32'(out_step), 32'd0);
        step_wait(2'd1, 8, n);
        check("mid_rst_lat", 32'(n), 32'd4);
        check("mid_rst_scan", 32'(out_leds), 32'b0001);

        // Random run/mode/reset traffic against the model
        rmode = 2'd0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) rmode = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 3) != 0), rmode, ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
